// File: rtl/id_ex_fwd_stage_pkg.sv
// Shared constants for the ID/EX pipeline register and its forwarding-select logic.
// Select encodings drive the EX-stage 3:1 operand muxes directly.
package id_ex_fwd_stage_pkg;
   localparam logic [1:0] FWD_REG        = 2'b00;
   localparam logic [1:0] FWD_WB         = 2'b01;
   localparam logic [1:0] FWD_MEM        = 2'b10;
   localparam logic [4:0] REG_ZERO       = 5'd0;
   localparam int         CTRL_W_DEFAULT = 16;
endpackage

// File: rtl/id_ex_fwd_stage_fwd_sel_calc.sv
// Per-operand forwarding priority: EX producer beats MEM producer beats same-cycle WB write.
// The WB case keeps the register-operand select and asks the caller to capture wb data instead.
module id_ex_fwd_stage_fwd_sel_calc
   import id_ex_fwd_stage_pkg::*;
(
   input  logic [4:0] rs_i,
   input  logic       uses_i,
   input  logic       ex_valid_i,
   input  logic       ex_reg_write_i,
   input  logic [4:0] ex_rd_i,
   input  logic       mem_reg_write_i,
   input  logic [4:0] mem_rd_i,
   input  logic       wb_reg_write_i,
   input  logic [4:0] wb_rd_i,
   output logic [1:0] sel_o,
   output logic       wb_bypass_o
);
   always_comb begin
      sel_o       = FWD_REG;
      wb_bypass_o = 1'b0;
      if (rs_i != REG_ZERO && uses_i) begin
         if (ex_valid_i && ex_reg_write_i && ex_rd_i == rs_i) begin
            sel_o = FWD_MEM;
         end else if (mem_reg_write_i && mem_rd_i == rs_i) begin
            sel_o = FWD_WB;
         end else if (wb_reg_write_i && wb_rd_i == rs_i) begin
            wb_bypass_o = 1'b1;
         end
      end
   end
endmodule

// File: rtl/id_ex_fwd_stage.sv
// ID/EX pipeline register with registered forwarding selects, load-use detection and
// bubble insertion; the whole stage freezes on a global stall.
module id_ex_fwd_stage
   import id_ex_fwd_stage_pkg::*;
#(
   parameter int CTRL_W = CTRL_W_DEFAULT,
   parameter int XLEN   = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              stall_i,
   input  logic              flush_i,
   input  logic              id_valid_i,
   input  logic [XLEN-1:0]   id_pc_i,
   input  logic [4:0]        id_rs1_i,
   input  logic [4:0]        id_rs2_i,
   input  logic [4:0]        id_rd_i,
   input  logic              id_uses_rs1_i,
   input  logic              id_uses_rs2_i,
   input  logic [XLEN-1:0]   id_rs1_data_i,
   input  logic [XLEN-1:0]   id_rs2_data_i,
   input  logic [XLEN-1:0]   id_imm_i,
   input  logic [CTRL_W-1:0] id_ctrl_i,
   input  logic              id_reg_write_i,
   input  logic              id_mem_read_i,
   input  logic [4:0]        mem_rd_i,
   input  logic              mem_reg_write_i,
   input  logic [4:0]        wb_rd_i,
   input  logic              wb_reg_write_i,
   input  logic [XLEN-1:0]   wb_data_i,
   output logic              ex_valid_o,
   output logic              ex_reg_write_o,
   output logic              ex_mem_read_o,
   output logic [XLEN-1:0]   ex_pc_o,
   output logic [XLEN-1:0]   ex_imm_o,
   output logic [XLEN-1:0]   ex_rs1_data_o,
   output logic [XLEN-1:0]   ex_rs2_data_o,
   output logic [4:0]        ex_rs1_o,
   output logic [4:0]        ex_rs2_o,
   output logic [4:0]        ex_rd_o,
   output logic [CTRL_W-1:0] ex_ctrl_o,
   output logic [1:0]        fwd_a_sel_o,
   output logic [1:0]        fwd_b_sel_o,
   output logic              load_use_stall_o,
   output logic [31:0]       bubble_cnt_o
);
   logic              r_valid, r_reg_write, r_mem_read;
   logic [XLEN-1:0]   r_pc, r_imm, r_rs1_data, r_rs2_data;
   logic [4:0]        r_rs1, r_rs2, r_rd;
   logic [CTRL_W-1:0] r_ctrl;
   logic [1:0]        r_fwd_a, r_fwd_b;
   logic [31:0]       r_bubble_cnt;

   logic [1:0] w_a_sel, w_b_sel;
   logic       w_a_byp, w_b_byp;
   logic       w_load_use;

   // A load in EX cannot forward until it reaches MEM, so a dependent ID instruction waits one cycle.
   assign w_load_use = r_valid & r_mem_read & (r_rd != REG_ZERO) &
                       ((id_uses_rs1_i & (id_rs1_i == r_rd)) |
                        (id_uses_rs2_i & (id_rs2_i == r_rd))) &
                       id_valid_i & ~flush_i;

   id_ex_fwd_stage_fwd_sel_calc u_fwd_a (
      .rs_i            (id_rs1_i),
      .uses_i          (id_uses_rs1_i),
      .ex_valid_i      (r_valid),
      .ex_reg_write_i  (r_reg_write),
      .ex_rd_i         (r_rd),
      .mem_reg_write_i (mem_reg_write_i),
      .mem_rd_i        (mem_rd_i),
      .wb_reg_write_i  (wb_reg_write_i),
      .wb_rd_i         (wb_rd_i),
      .sel_o           (w_a_sel),
      .wb_bypass_o     (w_a_byp)
   );

   id_ex_fwd_stage_fwd_sel_calc u_fwd_b (
      .rs_i            (id_rs2_i),
      .uses_i          (id_uses_rs2_i),
      .ex_valid_i      (r_valid),
      .ex_reg_write_i  (r_reg_write),
      .ex_rd_i         (r_rd),
      .mem_reg_write_i (mem_reg_write_i),
      .mem_rd_i        (mem_rd_i),
      .wb_reg_write_i  (wb_reg_write_i),
      .wb_rd_i         (wb_rd_i),
      .sel_o           (w_b_sel),
      .wb_bypass_o     (w_b_byp)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_valid      <= 1'b0;
         r_reg_write  <= 1'b0;
         r_mem_read   <= 1'b0;
         r_pc         <= '0;
         r_imm        <= '0;
         r_rs1_data   <= '0;
         r_rs2_data   <= '0;
         r_rs1        <= REG_ZERO;
         r_rs2        <= REG_ZERO;
         r_rd         <= REG_ZERO;
         r_ctrl       <= '0;
         r_fwd_a      <= FWD_REG;
         r_fwd_b      <= FWD_REG;
         r_bubble_cnt <= '0;
      end else if (!stall_i) begin
         if (flush_i || w_load_use) begin
            // Bubble: only the fields that can cause side effects are cleared; datapath fields hold.
            r_valid      <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_ctrl       <= '0;
            r_fwd_a      <= FWD_REG;
            r_fwd_b      <= FWD_REG;
            r_bubble_cnt <= r_bubble_cnt + 32'd1;
         end else begin
            r_valid     <= id_valid_i;
            r_reg_write <= id_valid_i & id_reg_write_i;
            r_mem_read  <= id_valid_i & id_mem_read_i;
            r_pc        <= id_pc_i;
            r_imm       <= id_imm_i;
            r_rs1_data  <= w_a_byp ? wb_data_i : id_rs1_data_i;
            r_rs2_data  <= w_b_byp ? wb_data_i : id_rs2_data_i;
            r_rs1       <= id_rs1_i;
            r_rs2       <= id_rs2_i;
            r_rd        <= id_rd_i;
            r_ctrl      <= id_ctrl_i;
            r_fwd_a     <= w_a_sel;
            r_fwd_b     <= w_b_sel;
         end
      end
   end

   assign ex_valid_o       = r_valid;
   assign ex_reg_write_o   = r_reg_write;
   assign ex_mem_read_o    = r_mem_read;
   assign ex_pc_o          = r_pc;
   assign ex_imm_o         = r_imm;
   assign ex_rs1_data_o    = r_rs1_data;
   assign ex_rs2_data_o    = r_rs2_data;
   assign ex_rs1_o         = r_rs1;
   assign ex_rs2_o         = r_rs2;
   assign ex_rd_o          = r_rd;
   assign ex_ctrl_o        = r_ctrl;
   assign fwd_a_sel_o      = r_fwd_a;
   assign fwd_b_sel_o      = r_fwd_b;
   assign load_use_stall_o = w_load_use;
   assign bubble_cnt_o     = r_bubble_cnt;
endmodule

// File: doc/id_ex_fwd_stage.md
Name: id_ex_fwd_stage

Overview:
- ID/EX pipeline register for the 5-stage RV32I core.
- Captures decoded operands and control, inserts bubbles on flush or load-use, and holds on global stall.
- Pre-computes registered forwarding selects for the EX-stage 3:1 operand muxes (00 = register operand, 01 = WB data, 10 = MEM ALU result).
- Generates the load-use stall request back to IF/ID.

Parameters:
- CTRL_W, 16, width of opaque EX/MEM/WB control bundle passed through.
- XLEN, 32, datapath width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- stall_i  in  1  global memory/cache stall; freezes the stage
- flush_i  in  1  branch/jump redirect; next EX content becomes a bubble
- id_valid_i  in  1  ID holds a real instruction
- id_pc_i  in  XLEN  ID program counter
- id_rs1_i, id_rs2_i, id_rd_i  in  5 each  register indices
- id_uses_rs1_i, id_uses_rs2_i  in  1 each  instruction actually reads rs1/rs2
- id_rs1_data_i, id_rs2_data_i  in  XLEN each  register file read data
- id_imm_i  in  XLEN  immediate
- id_ctrl_i  in  CTRL_W  control bundle
- id_reg_write_i, id_mem_read_i  in  1 each  writes rd / is load
- mem_rd_i  in  5  rd of instruction currently in MEM
- mem_reg_write_i  in  1  MEM instruction writes rd
- wb_rd_i  in  5  rd being written this cycle
- wb_reg_write_i  in  1  WB write enable this cycle
- wb_data_i  in  XLEN  WB write data
- ex_valid_o, ex_reg_write_o, ex_mem_read_o  out  1 each
- ex_pc_o, ex_imm_o, ex_rs1_data_o, ex_rs2_data_o  out  XLEN each
- ex_rs1_o, ex_rs2_o, ex_rd_o  out  5 each
- ex_ctrl_o  out  CTRL_W
- fwd_a_sel_o, fwd_b_sel_o  out  2 each  EX operand mux selects
- load_use_stall_o  out  1  combinational; IF/ID must hold
- bubble_cnt_o  out  32  count of inserted bubbles

Behaviour:
- Reset: every registered output is 0, including fwd selects = 00 and bubble_cnt_o = 0. Asynchronous assert; synchronous-release tolerant.
- load_use_stall_o = ex_valid_o & ex_mem_read_o & ex_rd_o != 0 & ((id_uses_rs1_i & id_rs1_i == ex_rd_o) | (id_uses_rs2_i & id_rs2_i == ex_rd_o)) & id_valid_i & !flush_i. Purely combinational, no latency.
- Per-edge priority:
  1. stall_i: hold all registers, counter unchanged.
  2. flush_i: bubble.
  3. load_use_stall_o: bubble.
  4. Otherwise: load from ID.
- Bubble: valid, reg_write and mem_read = 0; ctrl = 0; fwd selects = 00; other fields don't-care (implementation holds them); bubble_cnt_o += 1, wraps at 2^32.
- Load, per operand X in {rs1, rs2}, evaluated on current-cycle values:
  - If id_rsX = 0 or !id_uses_rsX: sel = 00, data = id data.
  - Else if ex_valid_o & ex_reg_write_o & ex_rd_o == id_rsX: sel = 10. The producer will be in MEM next cycle.
  - Else if mem_reg_write_i & mem_rd_i == id_rsX: sel = 01. The producer will be in WB next cycle.
  - Else if wb_reg_write_i & wb_rd_i == id_rsX: sel = 00, data register captures wb_data_i (same-cycle WB bypass).
  - Else sel = 00, data = id_rsX_data_i.
- A load in EX matching an ID source never reaches the sel = 10 path, because load-use bubbles it first. After one bubble the load is in MEM, so sel resolves to 01.
- Loaded valid = id_valid_i. An invalid ID still loads, but reg_write and mem_read are forced to 0.
- The stall_i hold keeps the selects valid because the downstream stages also hold.
- Reset asserted mid-operation clears everything immediately, with no partial state.

Decomposition:
- Shared package holds:
  - FWD_REG = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10
  - REG_ZERO = 5'd0
  - CTRL_W default
- One natural sub-module, fwd_sel_calc: combinational per-operand priority compare producing {sel, use_wb_bypass}, instantiated twice.

Test Plan:
- Reset: assert rst_i mid-stream with ex_valid_o = 1 -> all outputs 0 on the same cycle, bubble_cnt_o = 0.
- Back-to-back ALU (add x5 -> add x6 uses x5): next cycle fwd_a_sel_o = 10; with one independent instruction between them -> 01; with two between, wb_rd_i = 5, wb_data_i = 0xDEADBEEF -> sel 00, ex_rs1_data_o = 0xDEADBEEF.
- Load-use: lw x7 in EX, ID uses x7 as rs2 -> load_use_stall_o = 1, next ex_valid_o = 0, bubble_cnt_o = 1; following cycle fwd_b_sel_o = 01. Same case with id_uses_rs2_i = 0 -> no stall.
- x0: ex_rd_o = 0, ex_reg_write_o = 1, ID rs1 = 0 -> fwd_a_sel_o = 00, no stall.
- Stall vs flush: stall_i = 1 and flush_i = 1 together for 3 cycles -> all outputs frozen, counter frozen; drop stall_i -> bubble inserted, counter + 1.
- Double match: EX and MEM both write x9, ID reads x9 -> sel = 10 (EX priority).
